// File: rtl/fetch_group_queue_if.sv
// Push/pop bundle between the fetch stage, the fetch group queue and the decoder.
interface fetch_group_queue_if #(
  parameter int FETCH_NUM = 2,
  parameter int POP_NUM   = 2,
  parameter int DEPTH     = 8
);
  logic                           flush;
  logic                           push_valid;
  logic [31:0]                    push_vaddr;
  logic [FETCH_NUM*32-1:0]        push_instr;
  logic [FETCH_NUM-1:0]           push_mask;
  logic                           push_ds_pending;
  logic                           push_is_ds;
  logic                           push_ready;
  logic                           push_replay;
  logic [$clog2(POP_NUM+1)-1:0]   pop_num;
  logic [POP_NUM*32-1:0]          pop_instr;
  logic [POP_NUM*32-1:0]          pop_vaddr;
  logic [POP_NUM-1:0]             pop_valid;
  logic [$clog2(DEPTH+1)-1:0]     count;
  logic                           empty;
  logic                           full;

  modport master (
    output flush, push_valid, push_vaddr, push_instr, push_mask,
           push_ds_pending, push_is_ds, pop_num,
    input  push_ready, push_replay, pop_instr, pop_vaddr, pop_valid,
           count, empty, full
  );

  modport slave (
    input  flush, push_valid, push_vaddr, push_instr, push_mask,
           push_ds_pending, push_is_ds, pop_num,
    output push_ready, push_replay, pop_instr, pop_vaddr, pop_valid,
           count, empty, full
  );
endinterface

// File: rtl/fetch_group_queue.sv
// Compacting instruction queue: masked fetch lanes in, up to POP_NUM out per cycle.
// Define FETCH_QUEUE_STATS_EN to add the stat_replay/stat_empty cycle counters.
module fetch_group_queue #(
  parameter int FETCH_NUM = 2,
  parameter int POP_NUM   = 2,
  parameter int DEPTH     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  fetch_group_queue_if.slave   bus
`ifdef FETCH_QUEUE_STATS_EN
  ,
  output logic [31:0]          stat_replay,
  output logic [31:0]          stat_empty
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [31:0]   instr_mem [DEPTH];
  logic [31:0]   vaddr_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_q;

  logic [CW-1:0] n;
  logic [CW-1:0] free;
  logic [CW-1:0] need;
  logic [CW-1:0] pop_cnt;
  logic [PW-1:0] lane_slot [FETCH_NUM];
  logic          push_accept;

  // Each valid lane lands at wr_ptr plus the number of valid lanes below it.
  always_comb begin
    n = '0;
    for (int i = 0; i < FETCH_NUM; i++) begin
      lane_slot[i] = wr_ptr + PW'(n);
      n = n + CW'(bus.push_mask[i]);
    end
  end

  // Space is judged on the registered count only; a same-cycle pop never helps.
  always_comb begin
    free        = CW'(DEPTH) - count_q;
    need        = n + CW'(bus.push_ds_pending);
    push_accept = bus.push_valid & ~bus.flush & (bus.push_is_ds | (free >= need));
  end

  assign bus.push_ready  = push_accept;
  assign bus.push_replay = bus.push_valid & ~bus.flush & ~push_accept;

  always_comb begin
    if (CW'(bus.pop_num) > count_q) pop_cnt = count_q;
    else                            pop_cnt = CW'(bus.pop_num);
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_accept) wr_ptr <= wr_ptr + PW'(n);
      rd_ptr  <= rd_ptr + PW'(pop_cnt);
      count_q <= count_q + (push_accept ? n : '0) - pop_cnt;
    end
  end

  // Storage has no reset; entries are only meaningful below count.
  always_ff @(posedge clk) begin
    if (!rst && push_accept) begin
      for (int i = 0; i < FETCH_NUM; i++) begin
        if (bus.push_mask[i]) begin
          instr_mem[lane_slot[i]] <= bus.push_instr[32*i +: 32];
          vaddr_mem[lane_slot[i]] <= bus.push_vaddr + 32'(4*i);
        end
      end
    end
  end

  always_comb begin
    bus.pop_instr = '0;
    bus.pop_vaddr = '0;
    bus.pop_valid = '0;
    for (int i = 0; i < POP_NUM; i++) begin
      bus.pop_instr[32*i +: 32] = instr_mem[rd_ptr + PW'(i)];
      bus.pop_vaddr[32*i +: 32] = vaddr_mem[rd_ptr + PW'(i)];
      bus.pop_valid[i]          = (count_q > CW'(i));
    end
  end

  assign bus.count = count_q;
  assign bus.empty = (count_q == '0);
  assign bus.full  = (count_q > CW'(DEPTH-FETCH_NUM-1));

`ifdef FETCH_QUEUE_STATS_EN
  // Statistics survive flush; only reset clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_replay <= '0;
      stat_empty  <= '0;
    end else begin
      if (bus.push_replay && (stat_replay != 32'hFFFF_FFFF)) stat_replay <= stat_replay + 32'd1;
      if (bus.empty && (stat_empty != 32'hFFFF_FFFF))        stat_empty  <= stat_empty + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fetch_group_queue.sv
// Directed and randomized checks of fetch_group_queue against a queue-based reference model.
module tb_fetch_group_queue;
  localparam int FN = 2;
  localparam int PN = 2;
  localparam int DEPTH = 8;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] va;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_group_queue_if #(.FETCH_NUM(FN), .POP_NUM(PN), .DEPTH(DEPTH)) ifc ();

`ifdef FETCH_QUEUE_STATS_EN
  logic [31:0] stat_replay;
  logic [31:0] stat_empty;
  fetch_group_queue #(.FETCH_NUM(FN), .POP_NUM(PN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(ifc), .stat_replay(stat_replay), .stat_empty(stat_empty));
`else
  fetch_group_queue #(.FETCH_NUM(FN), .POP_NUM(PN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(ifc));
`endif

  ent_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   m_replay = 0;
  int   m_empty = 0;
  bit   last_ready;
  bit   last_replay;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive, check combinational handshake, clock, update model, check state.
  task automatic step(input bit r, input bit f, input bit v, input logic [31:0] va,
                      input logic [63:0] ins, input logic [1:0] m, input bit dsp,
                      input bit isds, input logic [1:0] pn);
    int  n;
    int  free;
    int  pops;
    bit  rdy_e;
    bit  rep_e;
    bit  empty_pre;
    rst                 = r;
    ifc.flush           = f;
    ifc.push_valid      = v;
    ifc.push_vaddr      = va;
    ifc.push_instr      = ins;
    ifc.push_mask       = m;
    ifc.push_ds_pending = dsp;
    ifc.push_is_ds      = isds;
    ifc.pop_num         = pn;
    #1;
    n     = int'(m[0]) + int'(m[1]);
    free  = DEPTH - q.size();
    rdy_e = v && !f && (isds || free >= n + int'(dsp));
    rep_e = v && !f && !rdy_e;
    chk("push_ready", ifc.push_ready, rdy_e);
    chk("push_replay", ifc.push_replay, rep_e);
    tests++;
    assert (!(v && !f && !r && isds && n > free)) else begin
      fails++;
      $error("FAIL ds_overflow observed=%0d expected<=%0d", n, free);
    end
    last_ready  = ifc.push_ready;
    last_replay = ifc.push_replay;
    empty_pre   = (q.size() == 0);
    @(posedge clk);
    #1;
    if (r) begin
      q.delete();
      m_replay = 0;
      m_empty  = 0;
    end else begin
      if (rep_e) m_replay++;
      if (empty_pre) m_empty++;
      if (f) q.delete();
      else begin
        pops = (int'(pn) < q.size()) ? int'(pn) : q.size();
        repeat (pops) void'(q.pop_front());
        if (rdy_e) begin
          for (int i = 0; i < FN; i++)
            if (m[i]) q.push_back('{ins: ins[32*i +: 32], va: va + 32'(4*i)});
        end
      end
    end
    chk("count", ifc.count, q.size());
    chk("empty", ifc.empty, q.size() == 0);
    chk("full", ifc.full, q.size() > DEPTH - FN - 1);
    for (int i = 0; i < PN; i++) begin
      chk("pop_valid", ifc.pop_valid[i], q.size() > i);
      if (i < q.size()) begin
        chk("pop_instr", ifc.pop_instr[32*i +: 32], q[i].ins);
        chk("pop_vaddr", ifc.pop_vaddr[32*i +: 32], q[i].va);
      end
    end
`ifdef FETCH_QUEUE_STATS_EN
    chk("stat_replay", stat_replay, m_replay);
    chk("stat_empty", stat_empty, m_empty);
`endif
  endtask

  task automatic idle();
    step(0, 0, 0, 32'h0, 64'h0, 2'b00, 0, 0, 2'd0);
  endtask

  task automatic push2(input logic [31:0] va);
    step(0, 0, 1, va, {va ^ 32'h5A5A_0000, va ^ 32'h0000_A5A5}, 2'b11, 0, 0, 2'd0);
  endtask

  initial begin
    logic [31:0] va;
    logic [1:0]  m;
    bit          isds;
    int          n;
    ifc.flush = 0; ifc.push_valid = 0; ifc.push_vaddr = 0; ifc.push_instr = 0;
    ifc.push_mask = 0; ifc.push_ds_pending = 0; ifc.push_is_ds = 0; ifc.pop_num = 0;

    // Reset, including a reset that overrides a push and pop.
    step(1, 0, 0, 32'h0, 64'h0, 2'b00, 0, 0, 2'd0);
    step(1, 0, 1, 32'h40, 64'h1, 2'b11, 0, 0, 2'd2);
    chk("rst_count", ifc.count, 0);
    chk("rst_empty", ifc.empty, 1);
    chk("rst_full", ifc.full, 0);
    chk("rst_pop_valid", ifc.pop_valid, 2'b00);

    // Single upper lane compacts into slot 0 with lane-1 vaddr.
    step(0, 0, 1, 32'h1000, {32'h0000_AAAA, 32'h0000_5555}, 2'b10, 0, 0, 2'd0);
    chk("r41_pop_valid", ifc.pop_valid, 2'b01);
    chk("r41_vaddr", ifc.pop_vaddr[31:0], 32'h1004);
    chk("r41_instr", ifc.pop_instr[31:0], 32'hAAAA);
    chk("r41_count", ifc.count, 1);

    // Over-request is clamped to count.
    step(0, 0, 0, 32'h0, 64'h0, 2'b00, 0, 0, 2'd2);
    chk("r45_count", ifc.count, 0);
    chk("r45_empty", ifc.empty, 1);

    // Delay-slot reservation at count=6.
    push2(32'h2000); push2(32'h2008); push2(32'h2010);
    step(0, 0, 1, 32'h2018, 64'h1111_2222_3333_4444, 2'b11, 1, 0, 2'd0);
    chk("r42_replay", last_replay, 1);
    chk("r42_count_hold", ifc.count, 6);
    step(0, 0, 1, 32'h2018, 64'h1111_2222_3333_4444, 2'b11, 0, 0, 2'd0);
    chk("r42_accept", last_ready, 1);
    chk("r42_count", ifc.count, 8);

    // Flush discards contents and the concurrent push.
    step(0, 1, 1, 32'h3000, 64'h5, 2'b11, 0, 0, 2'd2);
    chk("r45_flush_ready", last_ready, 0);
    chk("r45_flush_count", ifc.count, 0);

    // Delay slot accepted into the last free entry.
    push2(32'h4000); push2(32'h4008); push2(32'h4010);
    step(0, 0, 1, 32'h4018, 64'h77, 2'b01, 0, 0, 2'd0);
    chk("r43_pre_count", ifc.count, 7);
    step(0, 0, 1, 32'h4100, 64'h99, 2'b01, 0, 1, 2'd0);
    chk("r43_ready", last_ready, 1);
    chk("r43_count", ifc.count, 8);
    chk("r43_full", ifc.full, 1);
    step(0, 1, 0, 32'h0, 64'h0, 2'b00, 0, 0, 2'd0);

    // Streaming through pointer wrap.
    for (int k = 0; k < 5; k++)
      step(0, 0, 1, 32'h5000 + 32'(8*k), {32'(k*2+1), 32'(k*2)}, 2'b11, 0, 0, 2'd2);
    for (int k = 0; k < 4; k++) step(0, 0, 0, 32'h0, 64'h0, 2'b00, 0, 0, 2'd2);
    chk("r44_drained", ifc.empty, 1);

    // Replay cycles at full, then reset.
    step(1, 0, 0, 32'h0, 64'h0, 2'b00, 0, 0, 2'd0);
    push2(32'h6000); push2(32'h6008); push2(32'h6010); push2(32'h6018);
    for (int k = 0; k < 3; k++) push2(32'h6100);
`ifdef FETCH_QUEUE_STATS_EN
    chk("r46_stat_replay", stat_replay, 3);
`endif
    step(1, 0, 0, 32'h0, 64'h0, 2'b00, 0, 0, 2'd0);
`ifdef FETCH_QUEUE_STATS_EN
    chk("r46_stat_rst", stat_replay, 0);
`endif
    idle();

    // Randomized traffic against the model.
    for (int k = 0; k < 600; k++) begin
      va   = {$urandom_range(0, 32'hFFFF), 2'b00} ;
      m    = 2'($urandom_range(0, 3));
      isds = ($urandom_range(0, 7) == 0);
      n    = int'(m[0]) + int'(m[1]);
      if (isds && n > DEPTH - q.size()) isds = 0;
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 24) == 0),
           1'($urandom_range(0, 3) != 0), va, {$urandom, $urandom}, m,
           ($urandom_range(0, 3) == 0), isds, 2'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fetch_group_queue.md
FETCH_GROUP_QUEUE -- requirements
Module: fetch_group_queue

Interface
REQ-001 SHALL have parameter FETCH_NUM, default 2: instruction lanes per pushed fetch group; power of 2, at least 1.
REQ-002 SHALL have parameter POP_NUM, default 2: maximum instructions popped per cycle; at least 1.
REQ-003 SHALL have parameter DEPTH, default 8: instruction entries; power of 2, at least FETCH_NUM+1 and at least POP_NUM.
REQ-004 SHALL have port clk, input, 1 bit: clock.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port flush, input, 1 bit: discard all contents.
REQ-007 SHALL have port push_valid, input, 1 bit: a fetch group is offered.
REQ-008 SHALL have port push_vaddr, input, 32 bits: vaddr of lane 0.
REQ-009 SHALL have port push_instr, input, FETCH_NUM*32 bits: lane i in bits [32i+31:32i].
REQ-010 SHALL have port push_mask, input, FETCH_NUM bits: valid lanes; may be non-contiguous.
REQ-011 SHALL have port push_ds_pending, input, 1 bit: group ends in a taken branch whose delay slot is not yet fetched.
REQ-012 SHALL have port push_is_ds, input, 1 bit: group carries only that delay slot.
REQ-013 SHALL have port push_ready, output, 1 bit: group accepted this cycle.
REQ-014 SHALL have port push_replay, output, 1 bit: group rejected; the upstream refetches it.
REQ-015 SHALL have port pop_num, input, $clog2(POP_NUM+1) bits: instructions consumed this cycle.
REQ-016 SHALL have port pop_instr, output, POP_NUM*32 bits: popped instructions.
REQ-017 SHALL have port pop_vaddr, output, POP_NUM*32 bits: vaddrs of the popped instructions.
REQ-018 SHALL have port pop_valid, output, POP_NUM bits: per-lane output valid.
REQ-019 SHALL have port count, output, $clog2(DEPTH+1) bits: occupancy.
REQ-020 SHALL have port empty, output, 1 bit: count==0.
REQ-021 SHALL have port full, output, 1 bit: count>DEPTH-FETCH_NUM-1.

Function
REQ-022 SHALL treat n = popcount(push_mask) and free = DEPTH-count, using registered count; a same-cycle pop SHALL NOT create space.
REQ-023 SHALL set push_ready = push_valid & ~flush & (push_is_ds | free >= n + push_ds_pending), combinationally.
REQ-024 SHALL set push_replay = push_valid & ~flush & ~push_ready.
REQ-025 SHALL write accepted masked lanes in ascending lane order to consecutive slots from the write pointer, with no holes.
REQ-026 SHALL give lane i the vaddr push_vaddr+4*i.
REQ-027 SHALL wrap both pointers modulo DEPTH.
REQ-028 SHALL advance the write pointer by n; n==0 with push_valid SHALL be accepted and change no state.
REQ-029 SHALL drive pop lane i with the entry at read pointer + i; pop_valid[i] = (count > i).
REQ-030 SHALL advance the read pointer by min(pop_num, count); pop_num > count SHALL be clamped, not underflow.
REQ-031 SHALL make a pushed entry visible on pop lanes the cycle after acceptance, with no same-cycle bypass.
REQ-032 SHALL update count as count + accepted n - popped, when push and pop occur in the same cycle.
REQ-033 SHALL on flush zero both pointers and count next cycle; a same-cycle push and pop are discarded.
REQ-034 SHALL keep count <= DEPTH at all times; push_is_ds with n > free is an upstream protocol violation, flagged by a bench assertion.

Reset
REQ-035 SHALL on rst clear pointers and count to 0, giving pop_valid=0, empty=1, full=0.
REQ-036 SHALL let rst override flush, push and pop in the same cycle.
REQ-037 SHALL NOT reset the storage array.

Configuration
REQ-038 SHALL with macro FETCH_QUEUE_STATS_EN defined add outputs stat_replay and stat_empty, 32 bits each, counting cycles with push_replay=1 and cycles with empty=1.
REQ-039 SHALL make the stat counters saturate at 32'hFFFFFFFF, clear on rst, and be unaffected by flush.
REQ-040 SHALL without FETCH_QUEUE_STATS_EN omit both ports and counters; all other behaviour is identical.

Verification (FETCH_NUM=2, POP_NUM=2, DEPTH=8)
REQ-041 SHALL cover: push mask=2'b10, vaddr=0x1000, instr lane1=0xAAAA -> next cycle pop_valid=2'b01, pop_vaddr[0]=0x1004, pop_instr[0]=0xAAAA, count=1.
REQ-042 SHALL cover: count=6, push mask=2'b11, ds_pending=1 -> push_replay=1, count stays 6; the same push with ds_pending=0 -> accepted, count=8.
REQ-043 SHALL cover: count=7, push_is_ds=1, mask=2'b01 -> push_ready=1, count=8, full=1.
REQ-044 SHALL cover: 5 pushes of 2 with pop_num=2 each cycle -> pointers wrap past 7, instructions pop in push order with no loss.
REQ-045 SHALL cover: count=1, pop_num=2 -> count=0, empty=1; flush asserted with push_valid -> count=0 next cycle, push_ready=0.
REQ-046 SHALL cover: with FETCH_QUEUE_STATS_EN, 3 replay cycles -> stat_replay=3; rst -> stat_replay=0.
